pc_unit: RTL and testbench

- Parametrised program-counter unit; successor to the fixed 32-bit always-enabled PC register.
- Holds the fetch PC and computes the next PC from prioritised sources: exception vector, return-address stack (RAS), redirect target, sequential increment.
- Adds stall, exception vectoring and a DEPTH-entry circular return-address stack.
- Sits at the fetch stage: feeds the instruction-memory address, and is driven by decode/execute redirect and stall logic.

---
 rtl/pc_pkg.sv | 22 ++
 rtl/pc_ras.sv | 63 ++++++
 rtl/pc_unit.sv | 111 +++++++++++
 tb/tb_pc_unit.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// pc_pkg: shared definitions for the program-counter unit.
//   - Default reset/exception vectors and sequential increment (32-bit
//     values; instances narrower than 32 bits truncate them).
//   - next_pc_sel_t: which source drives the next fetch PC, listed in
//     priority order, highest first.
package pc_pkg;

    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_EXC_VECTOR   = 32'h0000_0100;
    localparam logic [31:0] DEFAULT_INC          = 32'h0000_0001;

    typedef enum logic [2:0] {
        SEL_RESET = 3'd0,
        SEL_EXC   = 3'd1,
        SEL_HOLD  = 3'd2,
        SEL_RET   = 3'd3,
        SEL_CALL  = 3'd4,
        SEL_REDIR = 3'd5,
        SEL_SEQ   = 3'd6
    } next_pc_sel_t;

endpackage

// File: rtl/pc_ras.sv
// pc_ras: circular return-address stack.
//   clock, reset     : rising-edge clock, synchronous active-high reset
//   push, push_data  : write push_data at the write pointer, advance pointer
//   pop              : retreat the pointer (caller only pops when not empty)
//   top              : most recently pushed live entry, 0 when empty
//   count            : number of valid entries (0..DEPTH)
//   empty, full      : count == 0, count == DEPTH
// A push while full overwrites the oldest entry, which is simply the slot the
// write pointer has wrapped around to; count saturates at DEPTH.
module pc_ras
    import pc_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         push_data,
    output logic [WIDTH-1:0]         top,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] entries [DEPTH];
    logic [PW-1:0]    ptr;
    logic [PW-1:0]    ptr_m1;

    // DEPTH is a power of two, so pointer arithmetic wraps for free.
    assign ptr_m1 = ptr - PW'(1);
    assign empty  = (count == '0);
    assign full   = (count == CW'(DEPTH));
    assign top    = empty ? '0 : entries[ptr_m1];

    always_ff @(posedge clock) begin
        if (reset) begin
            ptr   <= '0;
            count <= '0;
        end else if (push) begin
            ptr <= ptr + PW'(1);
            if (!full) begin
                count <= count + CW'(1);
            end
        end else if (pop && !empty) begin
            ptr   <= ptr_m1;
            count <= count - CW'(1);
        end
    end

    // Storage needs no reset: top is masked to 0 while empty, and every
    // live entry has been written by a push.
    always_ff @(posedge clock) begin
        if (!reset && push) begin
            entries[ptr] <= push_data;
        end
    end

endmodule

// File: rtl/pc_unit.sv
// pc_unit: fetch-stage program counter with exception vectoring, stall and a
// return-address stack.
//   clock, reset      : rising-edge clock, synchronous active-high reset
//   stall             : hold PC and RAS this cycle (exc still wins)
//   redirect          : load redirect_target
//   redirect_target   : branch/jump/call target
//   call              : push pc_plus onto the RAS, go to redirect_target
//   ret               : pop the RAS and go to the popped address
//   exc               : go to EXC_VECTOR
//   pc_current        : registered fetch PC
//   pc_plus           : pc_current + INC, wraps mod 2^WIDTH
//   ras_top/count/empty/full : RAS status, combinational from its registers
//   ret_underflow     : one-cycle pulse after a ret taken with an empty RAS
module pc_unit
    import pc_pkg::*;
#(
    parameter int               WIDTH        = 32,
    parameter logic [WIDTH-1:0] INC          = WIDTH'(DEFAULT_INC),
    parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(DEFAULT_RESET_VECTOR),
    parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(DEFAULT_EXC_VECTOR),
    parameter int               DEPTH        = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    stall,
    input  logic                    redirect,
    input  logic [WIDTH-1:0]        redirect_target,
    input  logic                    call,
    input  logic                    ret,
    input  logic                    exc,
    output logic [WIDTH-1:0]        pc_current,
    output logic [WIDTH-1:0]        pc_plus,
    output logic [WIDTH-1:0]        ras_top,
    output logic [$clog2(DEPTH):0]  ras_count,
    output logic                    ras_empty,
    output logic                    ras_full,
    output logic                    ret_underflow
);

    next_pc_sel_t     sel;
    logic [WIDTH-1:0] pc_next;
    logic             ras_push;
    logic             ras_pop;
    logic             underflow_next;

    assign pc_plus = pc_current + INC;

    always_comb begin
        sel = SEL_SEQ;
        if (reset)         sel = SEL_RESET;
        else if (exc)      sel = SEL_EXC;
        else if (stall)    sel = SEL_HOLD;
        else if (ret)      sel = SEL_RET;
        else if (call)     sel = SEL_CALL;
        else if (redirect) sel = SEL_REDIR;
    end

    always_comb begin
        pc_next        = pc_plus;
        ras_push       = 1'b0;
        ras_pop        = 1'b0;
        underflow_next = 1'b0;
        case (sel)
            SEL_RESET: pc_next = RESET_VECTOR;
            SEL_EXC:   pc_next = EXC_VECTOR;
            SEL_HOLD:  pc_next = pc_current;
            SEL_RET: begin
                // Empty stack: fall through sequentially and flag it.
                if (ras_empty) begin
                    pc_next        = pc_plus;
                    underflow_next = 1'b1;
                end else begin
                    pc_next = ras_top;
                    ras_pop = 1'b1;
                end
            end
            SEL_CALL: begin
                pc_next  = redirect_target;
                ras_push = 1'b1;
            end
            SEL_REDIR: pc_next = redirect_target;
            default:   pc_next = pc_plus;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pc_current    <= RESET_VECTOR;
            ret_underflow <= 1'b0;
        end else begin
            pc_current    <= pc_next;
            ret_underflow <= underflow_next;
        end
    end

    pc_ras #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) u_ras (
        .clock    (clock),
        .reset    (reset),
        .push     (ras_push),
        .pop      (ras_pop),
        .push_data(pc_plus),
        .top      (ras_top),
        .count    (ras_count),
        .empty    (ras_empty),
        .full     (ras_full)
    );

endmodule

// File: tb/tb_pc_unit.sv
module tb_pc_unit;

    localparam int DEPTH = 4;

    // ---------------- clock / reset block ----------------
    logic clock = 1'b0;
    always #5 clock = ~clock;

    // 32-bit instance signals
    logic        reset = 1'b1, stall = 1'b0, redirect = 1'b0, call = 1'b0, ret = 1'b0, exc = 1'b0;
    logic [31:0] redirect_target = '0;
    logic [31:0] pc_current, pc_plus, ras_top;
    logic [2:0]  ras_count;
    logic        ras_empty, ras_full, ret_underflow;

    // 8-bit instance signals
    logic        reset_b = 1'b1, stall_b = 1'b0, redirect_b = 1'b0, call_b = 1'b0, ret_b = 1'b0, exc_b = 1'b0;
    logic [7:0]  target_b = '0;
    logic [7:0]  pc_b, pc_plus_b, ras_top_b;
    logic [2:0]  ras_count_b;
    logic        ras_empty_b, ras_full_b, ret_underflow_b;

    pc_unit dut (
        .clock(clock), .reset(reset), .stall(stall), .redirect(redirect),
        .redirect_target(redirect_target), .call(call), .ret(ret), .exc(exc),
        .pc_current(pc_current), .pc_plus(pc_plus), .ras_top(ras_top),
        .ras_count(ras_count), .ras_empty(ras_empty), .ras_full(ras_full),
        .ret_underflow(ret_underflow)
    );

    pc_unit #(
        .WIDTH(8), .INC(8'd1), .RESET_VECTOR(8'h00), .EXC_VECTOR(8'h80), .DEPTH(DEPTH)
    ) dut_b (
        .clock(clock), .reset(reset_b), .stall(stall_b), .redirect(redirect_b),
        .redirect_target(target_b), .call(call_b), .ret(ret_b), .exc(exc_b),
        .pc_current(pc_b), .pc_plus(pc_plus_b), .ras_top(ras_top_b),
        .ras_count(ras_count_b), .ras_empty(ras_empty_b), .ras_full(ras_full_b),
        .ret_underflow(ret_underflow_b)
    );

    // ---------------- reference model / scoreboard ----------------
    // exp_q holds live return addresses, back = top of stack.
    logic [31:0] exp_q[$];
    logic [31:0] m_pc;
    logic        m_uf;
    int          checks = 0;
    int          fails  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_update();
        m_uf = 1'b0;
        if (reset) begin
            m_pc = 32'h0;
            exp_q.delete();
        end else if (exc) begin
            m_pc = 32'h100;
        end else if (stall) begin
            // hold
        end else if (ret) begin
            if (exp_q.size() > 0) m_pc = exp_q.pop_back();
            else begin
                m_pc = m_pc + 32'd1;
                m_uf = 1'b1;
            end
        end else if (call) begin
            exp_q.push_back(m_pc + 32'd1);
            if (exp_q.size() > DEPTH) void'(exp_q.pop_front());
            m_pc = redirect_target;
        end else if (redirect) begin
            m_pc = redirect_target;
        end else begin
            m_pc = m_pc + 32'd1;
        end
    endtask

    task automatic check_all();
        logic [31:0] top_e;
        top_e = (exp_q.size() > 0) ? exp_q[$] : 32'h0;
        chk("pc_current", pc_current, m_pc);
        chk("pc_plus", pc_plus, m_pc + 32'd1);
        chk("ras_top", ras_top, top_e);
        chk("ras_count", 32'(ras_count), 32'(exp_q.size()));
        chk("ras_empty", 32'(ras_empty), 32'(exp_q.size() == 0));
        chk("ras_full", 32'(ras_full), 32'(exp_q.size() == DEPTH));
        chk("ret_underflow", 32'(ret_underflow), 32'(m_uf));
    endtask

    // ---------------- driver tasks ----------------
    // Apply inputs, advance one edge, compare against the model #1 later.
    task automatic drive(input logic r, input logic e, input logic s, input logic rt,
                         input logic c, input logic rd, input logic [31:0] tgt);
        reset = r; exc = e; stall = s; ret = rt; call = c; redirect = rd;
        redirect_target = tgt;
        model_update();
        @(posedge clock);
        #1;
        check_all();
        reset = 0; exc = 0; stall = 0; ret = 0; call = 0; redirect = 0;
    endtask

    task automatic idle();                   drive(0, 0, 0, 0, 0, 0, 32'h0); endtask
    task automatic jump(input logic [31:0] t); drive(0, 0, 0, 0, 0, 1, t);  endtask
    task automatic do_call(input logic [31:0] t); drive(0, 0, 0, 0, 1, 0, t); endtask
    task automatic do_ret();                 drive(0, 0, 0, 1, 0, 0, 32'h0); endtask

    task automatic step_b(input logic r, input logic c, input logic rd, input logic [7:0] t);
        reset_b = r; call_b = c; redirect_b = rd; target_b = t;
        @(posedge clock);
        #1;
        reset_b = 0; call_b = 0; redirect_b = 0;
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        m_pc = '0;
        m_uf = 1'b0;
        #1;

        // reset, then three idle cycles
        drive(1, 0, 0, 0, 0, 0, 32'h0);
        chk("reset_pc", pc_current, 32'h0);
        idle(); chk("idle1", pc_current, 32'h1);
        idle(); chk("idle2", pc_current, 32'h2);
        idle(); chk("idle3", pc_current, 32'h3);
        chk("idle_empty", 32'(ras_empty), 32'h1);

        // stall beats redirect
        idle(); idle(); chk("pc5", pc_current, 32'h5);
        drive(0, 0, 1, 0, 0, 1, 32'h40); chk("stall1", pc_current, 32'h5);
        drive(0, 0, 1, 0, 0, 1, 32'h40); chk("stall2", pc_current, 32'h5);
        jump(32'h40);                     chk("redirect", pc_current, 32'h40);

        // single call / ret
        jump(32'h10);
        do_call(32'h80);
        chk("call_pc", pc_current, 32'h80);
        chk("call_top", ras_top, 32'h11);
        chk("call_cnt", 32'(ras_count), 32'h1);
        do_ret();
        chk("ret_pc", pc_current, 32'h11);
        chk("ret_empty", 32'(ras_empty), 32'h1);

        // overflow: five calls into a four-deep stack
        for (int i = 1; i <= 5; i++) begin
            jump(32'(i * 16));
            do_call(32'h200);
        end
        chk("ovf_cnt", 32'(ras_count), 32'h4);
        chk("ovf_full", 32'(ras_full), 32'h1);
        do_ret(); chk("pop1", pc_current, 32'h51);
        do_ret(); chk("pop2", pc_current, 32'h41);
        do_ret(); chk("pop3", pc_current, 32'h31);
        do_ret(); chk("pop4", pc_current, 32'h21);
        do_ret();
        chk("uf_pc", pc_current, 32'h22);
        chk("uf_pulse", 32'(ret_underflow), 32'h1);
        idle();
        chk("uf_clear", 32'(ret_underflow), 32'h0);

        // exception beats stall and ret
        do_call(32'h33);
        do_call(32'h33);
        chk("pre_exc_cnt", 32'(ras_count), 32'h2);
        drive(0, 1, 1, 1, 0, 0, 32'h0);
        chk("exc_pc", pc_current, 32'h100);
        chk("exc_cnt", 32'(ras_count), 32'h2);

        // call and ret together: ret wins, no push
        drive(0, 0, 0, 1, 1, 1, 32'h700);
        chk("callret_cnt", 32'(ras_count), 32'h1);

        // randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            logic [31:0] t;
            t = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom();
            drive($urandom_range(0, 39) == 0, $urandom_range(0, 15) == 0,
                  $urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0, t);
        end

        // 8-bit instance: wrap, then reset colliding with a call
        step_b(1, 0, 0, 8'h00);
        chk("b_reset", 32'(pc_b), 32'h0);
        step_b(0, 0, 1, 8'hFF);
        chk("b_ff", 32'(pc_b), 32'hFF);
        chk("b_plus_wrap", 32'(pc_plus_b), 32'h0);
        step_b(0, 0, 0, 8'h00);
        chk("b_wrap", 32'(pc_b), 32'h0);
        step_b(0, 1, 0, 8'h40);
        chk("b_call_cnt", 32'(ras_count_b), 32'h1);
        step_b(1, 1, 0, 8'h90);
        chk("b_rst_pc", 32'(pc_b), 32'h0);
        chk("b_rst_cnt", 32'(ras_count_b), 32'h0);
        chk("b_rst_top", 32'(ras_top_b), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
